div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_step.sv | 24 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the iterative divider.
// Signed operation is enabled by defining DIV_UNIT_SIGNED_EN.
package div_unit_pkg;

  localparam logic [5:0] ALUCTRL_DIV = 6'h34;
  localparam int         DEF_WIDTH   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step of the divider.
// Purely combinational; instantiated once by div_unit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {i_rem, i_bit};
  assign w_diff  = w_trial - {1'b0, i_div};

  // Partial remainder stays below the divisor, so the top bit of the
  // difference is a clean borrow flag.
  assign o_q   = ~w_diff[WIDTH];
  assign o_rem = o_q ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider with fixed latency and held results.
// Define DIV_UNIT_SIGNED_EN for two's-complement operation.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       alu_ctrl,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [5:0] CNT_MAX = 6'(WIDTH);

  state_t r_state;
  state_t w_next;

  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo_w;
  logic [WIDTH-1:0] r_rem_w;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_zero;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_accept = start && !flush
                 && (alu_ctrl == ALUCTRL_DIV)
                 && (r_state == S_IDLE || r_state == S_DONE);
  assign w_zero   = (op_b == '0);

`ifdef DIV_UNIT_SIGNED_EN
  assign w_sa = op_a[WIDTH-1];
  assign w_sb = op_b[WIDTH-1];
`else
  assign w_sa = 1'b0;
  assign w_sb = 1'b0;
`endif

  assign w_mag_a = w_sa ? -op_a : op_a;
  assign w_mag_b = w_sb ? -op_b : op_b;
  assign w_fix_q = r_neg_q ? -r_quo_w : r_quo_w;
  assign w_fix_r = r_neg_r ? -r_rem_w : r_rem_w;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem_w),
    .i_bit (r_quo_w[WIDTH-1]),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) w_next = w_zero ? S_DONE : S_CALC;
          else          w_next = S_IDLE;
        end
        S_CALC: begin
          if (r_cnt == CNT_MAX) w_next = S_FIX;
        end
        S_FIX:   w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_quo_w    <= '0;
      r_rem_w    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_div   <= w_mag_b;
      r_quo_w <= w_mag_a;
      r_rem_w <= '0;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      // Zero divisor completes immediately with raw dividend as remainder.
      if (w_zero) begin
        r_quot     <= '1;
        r_rem      <= op_a;
        r_div_zero <= 1'b1;
      end
    end else if (!flush && r_state == S_CALC) begin
      if (r_cnt != CNT_MAX) begin
        r_rem_w <= w_rem_nxt;
        r_quo_w <= {r_quo_w[WIDTH-2:0], w_q_bit};
        r_cnt   <= r_cnt + 6'd1;
      end
    end else if (!flush && r_state == S_FIX) begin
      r_quot     <= w_fix_q;
      r_rem      <= w_fix_r;
      r_div_zero <= 1'b0;
    end
  end

  assign busy     = (r_state == S_CALC) || (r_state == S_FIX);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_div_zero;
  assign quot     = r_quot;
  assign rem      = r_rem;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Signed vectors run only when DIV_UNIT_SIGNED_EN is defined.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  alu_ctrl;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quot;
  logic [31:0] rem;

  int n_run;
  int n_fail;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_ctrl (alu_ctrl),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quot     (quot),
    .rem      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered right after a negedge; accept happens at the next posedge.
  // Returns the cycle done appeared in (0 if never within 60 cycles).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int inj, input int fl,
                         output int lat, output bit ok);
    logic [31:0] q0;
    logic [31:0] r0;
    q0 = quot;
    r0 = rem;
    alu_ctrl = 6'h34;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'd3;
    lat = 0;
    ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (i < 35 && (fl == 0 || i <= fl) && !busy) ok = 1'b0;
      if (busy && (quot !== q0 || rem !== r0)) ok = 1'b0;
      start = (i == inj);
      if (i == inj) begin
        op_a = 32'd50;
        op_b = 32'd5;
      end
      flush = (i == fl);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    alu_ctrl = 6'h34;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_run++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000", {busy, done, div_zero});
    end
    n_run++;
    if (quot !== 32'd0 || rem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0/0", quot, rem);
    end
  endtask

  task automatic test_basic;
    int lat;
    bit ok;
    run_div(32'd100, 32'd7, 0, 0, lat, ok);
    n_run++;
    if (lat !== 35) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 35", lat);
    end
    n_run++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_busy_hold got 0 want 1");
    end
    n_run++;
    if (quot !== 32'd14 || rem !== 32'd2 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got %0d/%0d z%b want 14/2 z0",
               quot, rem, div_zero);
    end
    @(negedge clk);
    n_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse got d%b b%b want d0 b0", done, busy);
    end
  endtask

  task automatic test_vectors;
    int lat;
    bit ok;
    run_div(32'hFFFF_FFFF, 32'd1, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd0 || lat !== 35) begin
      n_fail++;
      $display("FAIL max_by_one got %h/%h lat %0d want ffffffff/0 lat 35",
               quot, rem, lat);
    end
    @(negedge clk);
    run_div(32'd5, 32'd9, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'd0 || rem !== 32'd5 || lat !== 35) begin
      n_fail++;
      $display("FAIL small_by_big got %0d/%0d lat %0d want 0/5 lat 35",
               quot, rem, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int lat;
    bit ok;
    run_div(32'd1234, 32'd0, 0, 0, lat, ok);
    n_run++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL dz_latency got %0d want 1", lat);
    end
    n_run++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd1234 || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result got %h/%0d z%b want ffffffff/1234 z1",
               quot, rem, div_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    alu_ctrl = 6'h34;
    op_a = 32'd100;
    op_b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    n_run++;
    if (busy !== 1'b1 || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre got b%b z%b want b1 z1", busy, div_zero);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_run++;
    if ({busy, done, div_zero} !== 3'b000 || quot !== 0 || rem !== 0) begin
      n_fail++;
      $display("FAIL rst_mid got b%b d%b z%b %h/%h want all 0",
               busy, done, div_zero, quot, rem);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    bit ok;
    run_div(32'd100, 32'd7, 10, 0, lat, ok);
    n_run++;
    if (quot !== 32'd14 || rem !== 32'd2 || lat !== 35 || !ok) begin
      n_fail++;
      $display("FAIL busy_ignore got %0d/%0d lat %0d ok %b want 14/2 lat 35",
               quot, rem, lat, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_opcode;
    bit seen;
    seen = 1'b0;
    alu_ctrl = 6'h13;
    op_a = 32'd77;
    op_b = 32'd0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    start = 1'b0;
    alu_ctrl = 6'h34;
    n_run++;
    if (seen || quot !== 32'd14) begin
      n_fail++;
      $display("FAIL bad_opcode got resp %b q %0d want resp 0 q 14",
               seen, quot);
    end
  endtask

  task automatic test_flush;
    int lat;
    bit ok;
    run_div(32'd5, 32'd9, 0, 20, lat, ok);
    n_run++;
    if (lat !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort got lat %0d b%b want lat 0 b0", lat, busy);
    end
    n_run++;
    if (quot !== 32'd14 || rem !== 32'd2 || !ok) begin
      n_fail++;
      $display("FAIL flush_hold got %0d/%0d ok %b want 14/2 ok 1",
               quot, rem, ok);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    run_div(32'd100, 32'd7, 0, 0, lat, ok);
    run_div(32'd1000, 32'd10, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'd100 || rem !== 32'd0 || lat !== 35 || !ok) begin
      n_fail++;
      $display("FAIL b2b_calc got %0d/%0d lat %0d want 100/0 lat 35",
               quot, rem, lat);
    end
    run_div(32'd9, 32'd0, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'd9 || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_zero got %h/%0d lat %0d want ffffffff/9 lat 1",
               quot, rem, lat);
    end
    @(negedge clk);
  endtask

`ifdef DIV_UNIT_SIGNED_EN
  task automatic test_signed;
    int lat;
    bit ok;
    run_div(-32'sd7, 32'sd2, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'hFFFF_FFFF || lat !== 35) begin
      n_fail++;
      $display("FAIL sgn_neg_a got %h/%h lat %0d want fffffffd/ffffffff 35",
               quot, rem, lat);
    end
    @(negedge clk);
    run_div(32'sd7, -32'sd2, 0, 0, lat, ok);
    n_run++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'd1 || lat !== 35) begin
      n_fail++;
      $display("FAIL sgn_neg_b got %h/%h lat %0d want fffffffd/1 35",
               quot, rem, lat);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    alu_ctrl = 6'h34;
    op_a = '0;
    op_b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_reset_mid();
    test_busy_ignore();
    test_bad_opcode();
    test_flush();
    test_back_to_back();
`ifdef DIV_UNIT_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
